// File: rtl/mux_scan_ctrl_if.sv
// Bundles the scan controller's control, mux and result signals.
// master is the controller side; slave is the surrounding logic (mux, host).
interface mux_scan_ctrl_if #(
  parameter int N_CH  = 10,
  parameter int SEL_W = 4
);
  logic             start;
  logic             abort;
  logic             mux_y;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  data_out;
  logic             ser_valid;
  logic             ser_bit;
  logic [SEL_W-1:0] ser_idx;

  modport master (
    input  start, abort, mux_y,
    output sel, busy, done, data_out, ser_valid, ser_bit, ser_idx
  );

  modport slave (
    output start, abort, mux_y,
    input  sel, busy, done, data_out, ser_valid, ser_bit, ser_idx
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through every channel, samples mux_y after DWELL cycles each, streams the bits.
// Latency N_CH*DWELL cycles from the start edge to done; start is ignored while busy, abort cancels at once.
module mux_scan_ctrl #(
  parameter int N_CH  = 10,
  parameter int SEL_W = 4,
  parameter int DWELL = 1,
  parameter int DW_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_ctrl_if.master  bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]       state;
  logic [DW_W-1:0]  dw_cnt;
  logic [N_CH-1:0]  shadow;
  logic [N_CH-1:0]  cap;
  logic [SEL_W-1:0] sel;
  logic             busy;
  logic             done;
  logic [N_CH-1:0]  data_out;
  logic             ser_valid;
  logic             ser_bit;
  logic [SEL_W-1:0] ser_idx;
  logic             dw_end;
  logic             last_ch;

  assign dw_end  = (dw_cnt == DW_W'(DWELL - 1));
  assign last_ch = (sel == SEL_W'(N_CH - 1));

  // Shadow word with the current channel's bit replaced by the live mux output.
  always_comb begin
    cap = shadow;
    for (int i = 0; i < N_CH; i++) begin
      if (SEL_W'(i) == sel) cap[i] = bus.mux_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dw_cnt    <= '0;
      shadow    <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      ser_valid <= 1'b0;
      ser_bit   <= 1'b0;
      ser_idx   <= '0;
    end else begin
      done      <= 1'b0;
      ser_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (bus.start && !bus.abort) begin
          state  <= S_SCAN;
          sel    <= '0;
          dw_cnt <= '0;
          busy   <= 1'b1;
          shadow <= '0;
        end
      end else if (bus.abort) begin
        // Abort wins over a coinciding sample edge: nothing is captured or streamed.
        state  <= S_IDLE;
        busy   <= 1'b0;
        sel    <= '0;
        dw_cnt <= '0;
      end else if (dw_end) begin
        shadow    <= cap;
        ser_valid <= 1'b1;
        ser_bit   <= bus.mux_y;
        ser_idx   <= sel;
        dw_cnt    <= '0;
        if (last_ch) begin
          data_out <= cap;
          done     <= 1'b1;
          busy     <= 1'b0;
          sel      <= '0;
          state    <= S_IDLE;
        end else begin
          sel <= sel + 1'b1;
        end
      end else begin
        dw_cnt <= dw_cnt + 1'b1;
      end
    end
  end

  assign bus.sel       = sel;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.data_out  = data_out;
  assign bus.ser_valid = ser_valid;
  assign bus.ser_bit   = ser_bit;
  assign bus.ser_idx   = ser_idx;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: DUT a uses DWELL=1, DUT b uses DWELL=3; a queue scoreboard
// holds the expected serial stream and captured words, compared when the DUT emits them.
module tb_mux_scan_ctrl;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;

  logic [9:0] d_a = '0;
  logic [9:0] d_b = '0;
  logic [4:0] qa[$];
  logic [4:0] qb[$];
  logic [9:0] dqa[$];
  logic [9:0] dqb[$];

  mux_scan_ctrl_if #(.N_CH(10), .SEL_W(4)) ifa ();
  mux_scan_ctrl_if #(.N_CH(10), .SEL_W(4)) ifb ();

  mux_scan_ctrl #(.N_CH(10), .SEL_W(4), .DWELL(1), .DW_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa)
  );
  mux_scan_ctrl #(.N_CH(10), .SEL_W(4), .DWELL(3), .DW_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb)
  );

  // Behavioural 10-to-1 mux in front of each DUT.
  assign ifa.mux_y = (ifa.sel < 4'd10) ? d_a[ifa.sel] : 1'b0;
  assign ifb.mux_y = (ifb.sel < 4'd10) ? d_b[ifb.sel] : 1'b0;

  logic [3:0] v_sel;
  logic       v_busy, v_done, v_sv;
  logic [9:0] v_data;
  assign v_sel  = (cur == 0) ? ifa.sel       : ifb.sel;
  assign v_busy = (cur == 0) ? ifa.busy      : ifb.busy;
  assign v_done = (cur == 0) ? ifa.done      : ifb.done;
  assign v_sv   = (cur == 0) ? ifa.ser_valid : ifb.ser_valid;
  assign v_data = (cur == 0) ? ifa.data_out  : ifb.data_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int w, input logic [9:0] d, input int n, input bit with_done);
    for (int k = 0; k < n; k++) begin
      if (w == 0) qa.push_back({4'(k), d[k]});
      else        qb.push_back({4'(k), d[k]});
    end
    if (with_done) begin
      if (w == 0) dqa.push_back(d);
      else        dqb.push_back(d);
    end
  endtask

  // Scoreboard consumers: every ser_valid/done must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [4:0] e;
    logic [9:0] dw;
    if (ifa.ser_valid) begin
      if (qa.size() == 0) chk("a_ser_unexpected", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_ser_idx", 32'(ifa.ser_idx), 32'(e[4:1]));
        chk("a_ser_bit", 32'(ifa.ser_bit), 32'(e[0]));
      end
    end
    if (ifa.done) begin
      if (dqa.size() == 0) chk("a_done_unexpected", 1, 0);
      else begin
        dw = dqa.pop_front();
        chk("a_data_out", 32'(ifa.data_out), 32'(dw));
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] e;
    logic [9:0] dw;
    if (ifb.ser_valid) begin
      if (qb.size() == 0) chk("b_ser_unexpected", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_ser_idx", 32'(ifb.ser_idx), 32'(e[4:1]));
        chk("b_ser_bit", 32'(ifb.ser_bit), 32'(e[0]));
      end
    end
    if (ifb.done) begin
      if (dqb.size() == 0) chk("b_done_unexpected", 1, 0);
      else begin
        dw = dqb.pop_front();
        chk("b_data_out", 32'(ifb.data_out), 32'(dw));
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_sel"},  32'(ifa.sel), 0);
    chk({tag, "_a_busy"}, 32'(ifa.busy), 0);
    chk({tag, "_a_done"}, 32'(ifa.done), 0);
    chk({tag, "_a_data"}, 32'(ifa.data_out), 0);
    chk({tag, "_a_sv"},   32'(ifa.ser_valid), 0);
    chk({tag, "_a_sbit"}, 32'(ifa.ser_bit), 0);
    chk({tag, "_a_sidx"}, 32'(ifa.ser_idx), 0);
    chk({tag, "_b_sel"},  32'(ifb.sel), 0);
    chk({tag, "_b_busy"}, 32'(ifb.busy), 0);
    chk({tag, "_b_data"}, 32'(ifb.data_out), 0);
  endtask

  // Full scan on DUT w with cycle-exact checks of sel, busy, ser_valid cadence and done.
  task automatic run_full(input int w, input logic [9:0] d);
    int dw;
    dw  = (w == 0) ? 1 : 3;
    cur = w;
    if (w == 0) d_a = d; else d_b = d;
    push_exp(w, d, 10, 1'b1);
    @(negedge clk);
    if (w == 0) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    for (int j = 0; j <= 10 * dw; j++) begin
      if (j > 0) @(negedge clk);
      if (j < 10 * dw) begin
        chk("scan_sel", 32'(v_sel), 32'(j / dw));
        chk("scan_busy", 32'(v_busy), 1);
        chk("scan_done_low", 32'(v_done), 0);
      end else begin
        chk("end_done", 32'(v_done), 1);
        chk("end_busy", 32'(v_busy), 0);
        chk("end_sel", 32'(v_sel), 0);
        chk("end_data", 32'(v_data), 32'(d));
      end
      chk("scan_ser_valid", 32'(v_sv), 32'(j > 0 && j % dw == 0));
    end
    @(negedge clk);
    chk("after_done_low", 32'(v_done), 0);
    chk("after_busy_low", 32'(v_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // Basic scans: DWELL=1 and DWELL=3 with alternating pattern.
    run_full(0, 10'b1010101010);
    run_full(1, 10'b1010101010);

    // Abort while sel=4 on a second scan; earlier captured word must survive.
    cur = 0;
    d_a = 10'h155;
    push_exp(0, 10'h155, 4, 1'b0);
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (int j = 0; j <= 4; j++) begin
      if (j > 0) @(negedge clk);
      chk("abort_pre_sel", 32'(ifa.sel), 32'(j));
    end
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.abort = 1'b0;
    chk("abort_busy", 32'(ifa.busy), 0);
    chk("abort_sel", 32'(ifa.sel), 0);
    chk("abort_sv", 32'(ifa.ser_valid), 0);
    chk("abort_done", 32'(ifa.done), 0);
    chk("abort_data_kept", 32'(ifa.data_out), 32'h2AA);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("abort_quiet_sv", 32'(ifa.ser_valid), 0);
      chk("abort_quiet_done", 32'(ifa.done), 0);
      chk("abort_quiet_busy", 32'(ifa.busy), 0);
    end

    // abort in IDLE blocks a coinciding start.
    ifa.start = 1'b1;
    ifa.abort = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifa.abort = 1'b0;
    chk("idle_abort_blocks_start", 32'(ifa.busy), 0);

    // start pulses mid-scan are ignored; start held through done chains a new scan.
    d_a = 10'h2AA;
    push_exp(0, 10'h2AA, 10, 1'b1);
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    for (int j = 0; j <= 22; j++) begin
      if (j > 0) @(negedge clk);
      ifa.start = (j == 2 || j == 6 || j == 9 || j == 10);
      if (j == 10) begin
        d_a = 10'h155;
        push_exp(0, 10'h155, 10, 1'b1);
      end
      if (j < 10) begin
        chk("ign_sel", 32'(ifa.sel), 32'(j));
        chk("ign_busy", 32'(ifa.busy), 1);
      end else if (j == 10) begin
        chk("ign_done", 32'(ifa.done), 1);
        chk("ign_data", 32'(ifa.data_out), 32'h2AA);
      end else if (j < 21) begin
        chk("b2b_sel", 32'(ifa.sel), 32'(j - 11));
        chk("b2b_busy", 32'(ifa.busy), 1);
      end else if (j == 21) begin
        chk("b2b_done", 32'(ifa.done), 1);
        chk("b2b_data", 32'(ifa.data_out), 32'h155);
      end
      if (j != 10 && j != 21) chk("ign_done_low", 32'(ifa.done), 0);
      chk("ign_sv", 32'(ifa.ser_valid), 32'((j >= 1 && j <= 10) || (j >= 12 && j <= 21)));
    end
    ifa.start = 1'b0;

    // Asynchronous reset mid-scan at sel=5, between clock edges.
    d_a = 10'h2AA;
    push_exp(0, 10'h2AA, 10, 1'b1);
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    for (int j = 1; j <= 5; j++) @(negedge clk);
    chk("pre_rst_sel", 32'(ifa.sel), 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    qa.delete();
    dqa.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_full(0, 10'h2AA);

    @(negedge clk);
    chk("sb_a_ser_empty", 32'(qa.size()), 0);
    chk("sb_b_ser_empty", 32'(qb.size()), 0);
    chk("sb_a_done_empty", 32'(dqa.size()), 0);
    chk("sb_b_done_empty", 32'(dqb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
